// File: rtl/decode_unit_if.sv
// decode_unit_if: fetch-to-decode handshake plus the decoded control bundle
interface decode_unit_if;
  logic [31:0] instruction;
  logic instr_valid;
  logic instr_ready;
  logic [2:0] inaddress;
  logic [2:0] out1address;
  logic [2:0] out2address;
  logic write;
  logic [7:0] immediate;
  logic [2:0] aluop;
  logic imm_sel;
  logic neg_sel;
  logic illegal;
  logic [7:0] retired;
  modport master (
    output instruction, instr_valid,
    input instr_ready, inaddress, out1address, out2address, write, immediate,
    aluop, imm_sel, neg_sel, illegal, retired
  );
  modport slave (
    input instruction, instr_valid,
    output instr_ready, inaddress, out1address, out2address, write, immediate,
    aluop, imm_sel, neg_sel, illegal, retired
  );
endinterface

// File: rtl/decode_unit.sv
// decode_unit: four-cycle IDLE/DECODE/EXEC/WB instruction decoder with retire counter
module decode_unit (
  input logic clk,
  input logic reset,
  decode_unit_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  state_t state;
  logic [31:0] ir;
  logic [7:0] op;
  logic legal;
  logic active;
  logic unused;
  assign op = ir[31:24];
  assign legal = op < 8'd6;
  assign active = (state != IDLE) && legal;
  assign unused = ^{ir[23:19], ir[15:11]};
  assign bus.inaddress = ir[18:16];
  assign bus.out1address = ir[2:0];
  assign bus.out2address = ir[10:8];
  assign bus.immediate = ir[7:0];
  // Control fields are forced to 0 in IDLE so reset (IR=0, opcode loadi) shows no IMM_SEL
  assign bus.aluop = !active ? 3'd0 :
                     (op == 8'd2 || op == 8'd3) ? 3'd1 :
                     op == 8'd4 ? 3'd2 :
                     op == 8'd5 ? 3'd3 : 3'd0;
  assign bus.imm_sel = active && op == 8'd0;
  assign bus.neg_sel = active && op == 8'd3;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      ir <= '0;
      bus.instr_ready <= 1'b0;
      bus.write <= 1'b0;
      bus.illegal <= 1'b0;
      bus.retired <= '0;
    end else begin
      bus.write <= 1'b0;
      bus.illegal <= 1'b0;
      case (state)
        IDLE:
          if (bus.instr_valid && bus.instr_ready) begin
            state <= DECODE;
            ir <= bus.instruction;
            bus.instr_ready <= 1'b0;
            bus.illegal <= bus.instruction[31:24] > 8'd5;
          end else bus.instr_ready <= 1'b1;
        DECODE:
          if (legal) state <= EXEC;
          else begin
            state <= IDLE;
            bus.instr_ready <= 1'b1;
          end
        EXEC: begin
          state <= WB;
          bus.write <= 1'b1;
        end
        WB: begin
          state <= IDLE;
          bus.instr_ready <= 1'b1;
          bus.retired <= bus.retired + 8'd1;
        end
      endcase
    end
endmodule
